// File: rtl/sched_pkg.sv
// Shared scheduler-side types and limits for the ready instruction queue.
package sched_pkg;

  localparam int INSTR_W_DEFAULT = 32;
  localparam int MAX_READY       = 3;
  localparam int MAX_PUSH        = 2;

  typedef logic [INSTR_W_DEFAULT-1:0] instr_t;
  typedef logic [1:0]                 ready_cnt_t;

endpackage

// File: rtl/ready_queue_storage.sv
// DEPTH x INSTR_W entry array: two in-order write ports at wr_addr, wr_addr+1 and
// three asynchronous read ports at consecutive addresses from rd_addr (all modulo DEPTH).
module ready_queue_storage
  import sched_pkg::*;
#(
  parameter  int DEPTH   = 8,
  parameter  int INSTR_W = INSTR_W_DEFAULT,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic                                  main_clk,
  input  logic                                  main_rst_n,
  input  logic [MAX_PUSH-1:0]                   wr_en,
  input  logic [AW-1:0]                         wr_addr,
  input  logic [MAX_PUSH-1:0][INSTR_W-1:0]      wr_data,
  input  logic [AW-1:0]                         rd_addr,
  output logic [MAX_READY-1:0][INSTR_W-1:0]     rd_data
);

  logic [DEPTH-1:0][INSTR_W-1:0] mem;

  // Address arithmetic is AW bits wide, so the two writes and the read window wrap naturally.
  always_ff @(posedge main_clk or negedge main_rst_n) begin
    if (!main_rst_n) begin
      mem <= '0;
    end else begin
      for (int p = 0; p < MAX_PUSH; p++) begin
        if (wr_en[p]) mem[wr_addr + AW'(p)] <= wr_data[p];
      end
    end
  end

  always_comb begin
    rd_data = '0;
    for (int k = 0; k < MAX_READY; k++) begin
      rd_data[k] = mem[rd_addr + AW'(k)];
    end
  end

endmodule

// File: rtl/ready_instruction_queue.sv
// Decoded-instruction FIFO feeding the scheduler; every output is derived from registered state.
// Optional starvation/backpressure counters are enabled by READY_QUEUE_STARVE_STATS_EN.
module ready_instruction_queue
  import sched_pkg::*;
#(
  parameter  int DEPTH   = 8,
  parameter  int INSTR_W = INSTR_W_DEFAULT,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic                              main_clk,
  input  logic                              main_rst_n,
  input  logic [1:0]                        push_count,
  input  logic [MAX_PUSH-1:0][INSTR_W-1:0]  push_instr,
  output logic [1:0]                        push_space,
  output ready_cnt_t                        ready_instruction_count_now,
  output logic [MAX_READY-1:0][INSTR_W-1:0] ready_instruction,
  input  ready_cnt_t                        used_ready_instruction_count,
  input  logic                              jump_triggering_now,
  output logic [AW:0]                       occupancy
`ifdef READY_QUEUE_STARVE_STATS_EN
  ,
  output logic [15:0]                       starve_cycles,
  output logic [15:0]                       backpressure_cycles
`endif
);

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  logic [AW-1:0]       rd_ptr;
  logic [AW-1:0]       wr_ptr;
  logic [AW:0]         occ;
  logic [AW:0]         free_slots;
  logic [MAX_PUSH-1:0] wr_en;

  // Handshake: decode may push at most push_space entries and the scheduler may retire at
  // most ready_instruction_count_now entries per cycle; both limits come from registered
  // state only, so neither side can form a combinational loop through this queue.
  assign free_slots = DEPTH_L - occ;
  assign push_space = (free_slots >= (AW+1)'(MAX_PUSH)) ? 2'(MAX_PUSH) : free_slots[1:0];
  assign ready_instruction_count_now =
      (occ >= (AW+1)'(MAX_READY)) ? 2'(MAX_READY) : occ[1:0];
  assign occupancy = occ;

  // A flushing cycle must not disturb storage, so its pushes are dropped at the write enables.
  assign wr_en[0] = !jump_triggering_now && (push_count != 2'd0);
  assign wr_en[1] = !jump_triggering_now && push_count[1];

  always_ff @(posedge main_clk or negedge main_rst_n) begin
    if (!main_rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ    <= '0;
    end else if (jump_triggering_now) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ    <= '0;
    end else begin
      rd_ptr <= rd_ptr + AW'(used_ready_instruction_count);
      wr_ptr <= wr_ptr + AW'(push_count);
      occ    <= occ - (AW+1)'(used_ready_instruction_count) + (AW+1)'(push_count);
    end
  end

  ready_queue_storage #(
    .DEPTH   (DEPTH),
    .INSTR_W (INSTR_W)
  ) u_storage (
    .main_clk   (main_clk),
    .main_rst_n (main_rst_n),
    .wr_en      (wr_en),
    .wr_addr    (wr_ptr),
    .wr_data    (push_instr),
    .rd_addr    (rd_ptr),
    .rd_data    (ready_instruction)
  );

`ifdef READY_QUEUE_STARVE_STATS_EN
  logic [15:0] starve_q;
  logic [15:0] backpressure_q;

  always_ff @(posedge main_clk or negedge main_rst_n) begin
    if (!main_rst_n) begin
      starve_q       <= '0;
      backpressure_q <= '0;
    end else if (jump_triggering_now) begin
      starve_q       <= '0;
      backpressure_q <= '0;
    end else begin
      if (occ == '0 && starve_q != 16'hFFFF) starve_q <= starve_q + 16'd1;
      if (push_space < 2'd2 && push_count == push_space && backpressure_q != 16'hFFFF)
        backpressure_q <= backpressure_q + 16'd1;
    end
  end

  assign starve_cycles       = starve_q;
  assign backpressure_cycles = backpressure_q;
`endif

  push_within_space: assert property (@(posedge main_clk) disable iff (!main_rst_n)
    push_count <= push_space);
  pop_within_ready: assert property (@(posedge main_clk) disable iff (!main_rst_n)
    used_ready_instruction_count <= ready_instruction_count_now);

endmodule

// File: doc/ready_instruction_queue.md
Name: ready_instruction_queue

Overview:
- Decoded-instruction FIFO directly upstream of the scheduler.
- Accepts up to 2 decoded instructions per cycle from decode.
- Presents the oldest up to 3 entries plus a 2-bit ready count, which feed the scheduler's ready_instruction_count_now.
- Retires exactly the number the scheduler reports in used_ready_instruction_count; a jump flushes the queue.

Parameters:
- DEPTH, 8, number of entries; power of two, at least 4.
- INSTR_W, 32, width of one decoded instruction word.

Ports:
- main_clk  input  1  sole clock, rising edge.
- main_rst_n  input  1  asynchronous active-low reset.
- push_count  input  2  instructions offered this cycle: 0, 1 or 2 (3 is illegal).
- push_instr  input  2 x INSTR_W  [0] is older, [1] is younger; only the first push_count entries are meaningful.
- push_space  output  2  min(2, DEPTH - occupancy); registered-state derived, so no input-to-output path.
- ready_instruction_count_now  output  2  min(3, occupancy).
- ready_instruction  output  3 x INSTR_W  [0] is head/oldest; entries at or beyond the ready count are don't-care.
- used_ready_instruction_count  input  2  number of head entries consumed this cycle.
- jump_triggering_now  input  1  flush request.
- occupancy  output  $clog2(DEPTH)+1  current number of valid entries.

Behaviour:
- State:
  - rd_ptr and wr_ptr, each $clog2(DEPTH) bits, wrap modulo DEPTH.
  - occ, $clog2(DEPTH)+1 bits.
  - Storage array DEPTH x INSTR_W.
- Reset (asynchronous, main_rst_n low):
  - rd_ptr=0, wr_ptr=0, occ=0.
  - ready_instruction_count_now=0, push_space=2, occupancy=0.
  - ready_instruction all zero; storage is cleared to zero.
- Output path:
  - ready_instruction_count_now, push_space, occupancy and ready_instruction are functions of registered state only.
  - This is mandatory: the scheduler derives its used count combinationally from ready_instruction_count_now, so any input-to-output path here forms a loop.
- Read window:
  - ready_instruction[k] = storage[(rd_ptr+k) mod DEPTH], for k=0..2.
  - Zero added latency: an entry is visible the cycle after it is written.
- Normal cycle (jump_triggering_now=0):
  - pop = used_ready_instruction_count.
  - push = push_count.
  - rd_ptr += pop; wr_ptr += push; occ <= occ - pop + push.
  - Writes go to storage[wr_ptr] and storage[wr_ptr+1], in order, modulo DEPTH.
- Simultaneous push and pop: legal in any combination.
  - push_space uses the pre-pop occ; pops in the same cycle do not raise it.
  - Full DEPTH with pop=2 and push=0 is legal.
- Flush (jump_triggering_now=1):
  - Next state is rd_ptr=wr_ptr=0, occ=0.
  - Same-cycle pushes and pops are discarded.
  - Storage contents are left unchanged.
  - Flush takes priority over everything except reset.
- Illegal inputs:
  - Upstream must guarantee push_count <= push_space.
  - The scheduler must guarantee used_ready_instruction_count <= ready_instruction_count_now.
  - Violations are flagged by simulation-only assertions. The state then follows the arithmetic, with no saturation.
- Wrap-around: pointer arithmetic is modulo DEPTH. The read window and the two-entry write may straddle index DEPTH-1 to 0.
- Reset mid-operation: asynchronous clear takes effect immediately; nothing is retained. On deassertion the queue behaves as empty.

Optional Feature:
- Macro: READY_QUEUE_STARVE_STATS_EN.
- When defined, the block adds two 16-bit saturating counters and their outputs:
  - starve_cycles: counts cycles where occ=0 and jump_triggering_now=0.
  - backpressure_cycles: counts cycles where push_space < 2 and push_count = push_space.
  - Both reset to 0 and clear on flush.
- When not defined, the counters and ports do not exist, and all other behaviour is identical.

Decomposition:
- Shared package sched_pkg holds:
  - instr_t (logic [INSTR_W-1:0]);
  - ready_cnt_t (logic [1:0]);
  - localparam MAX_READY=3 and MAX_PUSH=2.
- One sub-module, ready_queue_storage, is natural. It holds the DEPTH x INSTR_W array with 2 write ports and 3 asynchronous read ports at consecutive addresses.
- Pointer and occupancy control stays in ready_instruction_queue.

Test Plan:
- Reset check: hold main_rst_n low, then release:
  - ready_instruction_count_now=0, push_space=2, occupancy=0;
  - with push_count=0 and used=0 for 5 cycles, all three stay unchanged.
- Push and drain: push 2 per cycle for 4 cycles (A..H) with used=0:
  - occupancy 2,4,6,8;
  - push_space 2,2,2,0 at the final state;
  - ready_count=3 with window A,B,C;
  - then used=3, then 3, then 2: window D,E,F, then G,H, then count 0.
- Simultaneous push and pop at occ=3: push 2 and used 3 in the same cycle gives occ=2, with window holding the two new entries in order.
- Wrap: with rd_ptr=wr_ptr=6 and occ=0, push X,Y then Z,W:
  - X,Y written to indices 6,7; Z,W to 0,1;
  - window reads X,Y,Z across the wrap.
- Flush: at occ=5, assert jump_triggering_now with push_count=2 and used=1:
  - next cycle occ=0, ready count 0, push_space 2;
  - the dropped pushes never appear.
- Async reset mid-stream: at occ=6, pulse main_rst_n low between clock edges; outputs clear before the next edge.
- With READY_QUEUE_STARVE_STATS_EN defined: 10 idle empty cycles give starve_cycles=10; a flush returns it to 0.
